// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - requester and data-memory signals of the two-port data memory arbiter
interface dmem_arbiter_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);
   logic                  req0, req1;
   logic                  we0, we1;
   logic [DM_ADDRESS-1:0] addr0, addr1;
   logic [DATA_W-1:0]     wdata0, wdata1;
   logic [2:0]            funct3_0, funct3_1;
   logic                  gnt0, gnt1;
   logic                  done0, done1;
   logic                  err0, err1;
   logic [DATA_W-1:0]     rdata0, rdata1;
   logic [DM_ADDRESS-1:0] mem_addr;
   logic [3:0]            mem_wr;
   logic [DATA_W-1:0]     mem_wdata;
   logic [DATA_W-1:0]     mem_rdata;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, funct3_0, funct3_1,
      output gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
      output mem_addr, mem_wr, mem_wdata,
      input  mem_rdata
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, funct3_0, funct3_1,
      input  gnt0, gnt1, done0, done1, err0, err1, rdata0, rdata1,
      input  mem_addr, mem_wr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter and access sequencer for the byte-lane data memory
module dmem_arbiter #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t                state;
   logic                  last;
   logic                  own;
   logic                  c_we;
   logic                  c_bad;
   logic [2:0]            c_f3;
   logic [1:0]            c_lo;
   logic [DM_ADDRESS-1:0] mem_addr_q;
   logic [3:0]            mem_wr_q;
   logic [DATA_W-1:0]     mem_wdata_q;
   logic                  done_q;
   logic                  err_q;

   logic                  pick1, gnt0, gnt1;
   logic                  s_we, s_bad;
   logic [DM_ADDRESS-1:0] s_addr;
   logic [DATA_W-1:0]     s_wdata, s_lane_data;
   logic [2:0]            s_f3;
   logic [3:0]            s_lanes;
   logic [7:0]            rd_byte;
   logic [15:0]           rd_half;
   logic [DATA_W-1:0]     rd_ext;

   // On a tie the port that did not win last time takes it.
   always_comb begin
      pick1   = bus.req1 && (!bus.req0 || !last);
      gnt0    = !reset && (state == IDLE) && bus.req0 && !pick1;
      gnt1    = !reset && (state == IDLE) && pick1;
      s_we    = pick1 ? bus.we1      : bus.we0;
      s_addr  = pick1 ? bus.addr1    : bus.addr0;
      s_wdata = pick1 ? bus.wdata1   : bus.wdata0;
      s_f3    = pick1 ? bus.funct3_1 : bus.funct3_0;
   end

   always_comb begin
      s_bad       = 1'b0;
      s_lanes     = 4'b0000;
      s_lane_data = s_wdata;
      case (s_f3)
         3'b000: begin
            s_lanes     = 4'b0001 << s_addr[1:0];
            s_lane_data = {4{s_wdata[7:0]}};
         end
         3'b001: begin
            s_bad       = s_addr[0];
            s_lanes     = s_addr[1] ? 4'b1100 : 4'b0011;
            s_lane_data = {2{s_wdata[15:0]}};
         end
         3'b010: begin
            s_bad   = |s_addr[1:0];
            s_lanes = 4'b1111;
         end
         3'b100, 3'b101: s_bad = s_we || (s_f3[0] && s_addr[0]);
         default:        s_bad = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         last        <= 1'b1;
         own         <= 1'b0;
         c_we        <= 1'b0;
         c_bad       <= 1'b0;
         c_f3        <= 3'b000;
         c_lo        <= 2'b00;
         mem_addr_q  <= '0;
         mem_wr_q    <= 4'b0000;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state)
            IDLE: if (gnt0 || gnt1) begin
               state      <= ISSUE;
               last       <= pick1;
               own        <= pick1;
               c_we       <= s_we;
               c_bad      <= s_bad;
               c_f3       <= s_f3;
               c_lo       <= s_addr[1:0];
               mem_addr_q <= {s_addr[DM_ADDRESS-1:2], 2'b00};
               mem_wr_q   <= (s_we && !s_bad) ? s_lanes : 4'b0000;
               if (s_we && !s_bad)
                  mem_wdata_q <= s_lane_data;
            end
            ISSUE: begin
               state    <= RESP;
               mem_wr_q <= 4'b0000;
               done_q   <= 1'b1;
               err_q    <= c_bad;
            end
            RESP: begin
               state  <= IDLE;
               done_q <= 1'b0;
               err_q  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read word arrives in RESP, so load extraction stays combinational.
   always_comb begin
      rd_byte = bus.mem_rdata[{c_lo, 3'b000} +: 8];
      rd_half = c_lo[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
      rd_ext  = '0;
      case (c_f3)
         3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
         3'b010:  rd_ext = bus.mem_rdata;
         3'b100:  rd_ext = {24'h000000, rd_byte};
         3'b101:  rd_ext = {16'h0000, rd_half};
         default: rd_ext = '0;
      endcase
      if (c_we || c_bad || state != RESP)
         rd_ext = '0;
   end

   assign bus.gnt0      = gnt0;
   assign bus.gnt1      = gnt1;
   assign bus.done0     = done_q && !own;
   assign bus.done1     = done_q && own;
   assign bus.err0      = err_q && !own;
   assign bus.err1      = err_q && own;
   assign bus.rdata0    = own ? '0 : rd_ext;
   assign bus.rdata1    = own ? rd_ext : '0;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter against a byte-addressed access model
module tb_dmem_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   dmem_arbiter_if bus();
   dmem_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

   int vectors = 0;
   int miscompares = 0;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int w);
      return 32'h5A00_0000 ^ (w * 32'h0103_0507);
   endfunction

   // data memory: registered read, byte-lane writes
   logic [31:0] mem [0:127];
   always @(posedge clk) begin
      bus.mem_rdata <= mem[bus.mem_addr[8:2]];
      for (int k = 0; k < 4; k++)
         if (bus.mem_wr[k]) mem[bus.mem_addr[8:2]][8*k +: 8] <= bus.mem_wdata[8*k +: 8];
   end

   // reference model: flat byte array, one outstanding access, fixed 3-cycle occupancy
   logic [7:0]  mb [0:511];
   int          cyc = 0;
   bit          p_valid = 0;
   int          p_g;
   bit          p_port, p_we, p_bad;
   logic [2:0]  p_f3;
   logic [8:0]  p_addr;
   logic [31:0] p_wdata;
   bit          m_last = 1;
   bit          gnt_log[$];
   int          gcyc_log[$];

   initial begin
      logic [31:0] w;
      for (int i = 0; i < 128; i++) begin
         mem[i] = pat(i);
         w = pat(i);
         for (int k = 0; k < 4; k++) mb[4*i + k] = w[8*k +: 8];
      end
   end

   function automatic bit m_bad(input bit we, input logic [2:0] f3, input logic [8:0] a);
      bit legal;
      int sz;
      legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      sz = 1 << f3[1:0];
      return !legal || ((int'(a) % sz) != 0);
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [8:0] a);
      int sz;
      logic [31:0] v;
      sz = 1 << f3[1:0];
      v = 32'h0;
      for (int k = 0; k < sz; k++) v[8*k +: 8] = mb[int'(a) + k];
      if (!f3[2] && sz < 4 && v[8*sz-1])
         for (int k = sz; k < 4; k++) v[8*k +: 8] = 8'hFF;
      return v;
   endfunction

   always @(negedge clk) begin
      bit          eg0, eg1, ed0, ed1, ee0, ee1;
      logic [3:0]  ewr;
      logic [31:0] er0, er1, ewd, rv;
      int          sz;
      eg0 = 0; eg1 = 0; ed0 = 0; ed1 = 0; ee0 = 0; ee1 = 0;
      ewr = 4'b0000; er0 = 32'h0; er1 = 32'h0; ewd = 32'h0; rv = 32'h0;
      if (reset) begin
         p_valid = 0;
         m_last  = 1;
         chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
         chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
      end else if (!p_valid && (bus.req0 || bus.req1)) begin
         p_port  = (bus.req0 && bus.req1) ? !m_last : bus.req1;
         p_we    = p_port ? bus.we1 : bus.we0;
         p_f3    = p_port ? bus.funct3_1 : bus.funct3_0;
         p_addr  = p_port ? bus.addr1 : bus.addr0;
         p_wdata = p_port ? bus.wdata1 : bus.wdata0;
         p_bad   = m_bad(p_we, p_f3, p_addr);
         p_valid = 1;
         p_g     = cyc;
         m_last  = p_port;
         eg0 = !p_port;
         eg1 = p_port;
         gnt_log.push_back(p_port);
         gcyc_log.push_back(cyc);
      end else if (p_valid && cyc == p_g + 1) begin
         chk("issue_mem_addr", 32'(bus.mem_addr), 32'(p_addr) & 32'h1FC);
         if (p_we && !p_bad) begin
            sz = 1 << p_f3[1:0];
            for (int k = 0; k < sz; k++) begin
               ewr[(int'(p_addr) + k) % 4] = 1'b1;
               mb[int'(p_addr) + k] = p_wdata[8*k +: 8];
            end
            for (int l = 0; l < 4; l++) ewd[8*l +: 8] = p_wdata[8*(l % sz) +: 8];
            chk("issue_mem_wdata", bus.mem_wdata, ewd);
         end
      end else if (p_valid && cyc == p_g + 2) begin
         chk("resp_mem_addr", 32'(bus.mem_addr), 32'(p_addr) & 32'h1FC);
         rv = (p_we || p_bad) ? 32'h0 : m_load(p_f3, p_addr);
         if (p_port) begin ed1 = 1; ee1 = p_bad; er1 = rv; end
         else        begin ed0 = 1; ee0 = p_bad; er0 = rv; end
         p_valid = 0;
      end
      chk("gnt0", 32'(bus.gnt0), 32'(eg0));
      chk("gnt1", 32'(bus.gnt1), 32'(eg1));
      chk("mem_wr", 32'(bus.mem_wr), 32'(ewr));
      chk("done0", 32'(bus.done0), 32'(ed0));
      chk("done1", 32'(bus.done1), 32'(ed1));
      chk("err0", 32'(bus.err0), 32'(ee0));
      chk("err1", 32'(bus.err1), 32'(ee1));
      chk("rdata0", bus.rdata0, er0);
      chk("rdata1", bus.rdata1, er1);
      cyc++;
   end

   task automatic do_acc(input bit p, input bit we, input logic [2:0] f3, input logic [8:0] a,
                         input logic [31:0] wd, output logic [3:0] o_wr, output logic [31:0] o_wd,
                         output logic o_done, output logic o_err, output logic [31:0] o_rd);
      bit got;
      got = 0;
      o_wr = 4'hx; o_wd = 32'hx; o_done = 1'bx; o_err = 1'bx; o_rd = 32'hx;
      @(posedge clk); #1;
      if (p) begin
         bus.req1 = 1; bus.we1 = we; bus.funct3_1 = f3; bus.addr1 = a; bus.wdata1 = wd;
      end else begin
         bus.req0 = 1; bus.we0 = we; bus.funct3_0 = f3; bus.addr0 = a; bus.wdata0 = wd;
      end
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         got = p ? bus.gnt1 : bus.gnt0;
      end
      chk("grant_seen", 32'(got), 32'h1);
      @(posedge clk); #1;
      bus.req0 = 0;
      bus.req1 = 0;
      if (!got) return;
      @(negedge clk);
      o_wr = bus.mem_wr;
      o_wd = bus.mem_wdata;
      @(negedge clk);
      o_done = p ? bus.done1 : bus.done0;
      o_err  = p ? bus.err1 : bus.err0;
      o_rd   = p ? bus.rdata1 : bus.rdata0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  wr;
      logic [31:0] wd, rd;
      logic        dn, er;
      int          g0;
      logic [31:0] w;
      bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0; bus.funct3_0 = '0;
      bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0; bus.funct3_1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_lit_mem_wr", 32'(bus.mem_wr), 32'h0);
      chk("rst_lit_done0", 32'(bus.done0), 32'h0);
      chk("rst_lit_rdata1", bus.rdata1, 32'h0);
      @(posedge clk); #1 reset = 0;

      do_acc(0, 1, 3'b010, 9'h010, 32'hDEADBEEF, wr, wd, dn, er, rd);
      chk("sw_mem_wr", 32'(wr), 32'hF);
      do_acc(0, 0, 3'b010, 9'h010, 32'h0, wr, wd, dn, er, rd);
      chk("lw_done_at_t2", 32'(dn), 32'h1);
      chk("lw_err", 32'(er), 32'h0);
      chk("lw_rdata", rd, 32'hDEADBEEF);

      do_acc(0, 1, 3'b000, 9'h013, 32'h00000080, wr, wd, dn, er, rd);
      chk("sb_mem_wr", 32'(wr), 32'h8);
      do_acc(0, 0, 3'b000, 9'h013, 32'h0, wr, wd, dn, er, rd);
      chk("lb_rdata", rd, 32'hFFFFFF80);
      do_acc(1, 0, 3'b100, 9'h013, 32'h0, wr, wd, dn, er, rd);
      chk("lbu_rdata", rd, 32'h00000080);

      do_acc(1, 1, 3'b001, 9'h022, 32'hABCD1234, wr, wd, dn, er, rd);
      chk("sh_mem_wr", 32'(wr), 32'hC);
      chk("sh_mem_wdata", wd, 32'h12341234);
      do_acc(0, 0, 3'b001, 9'h022, 32'h0, wr, wd, dn, er, rd);
      chk("lh_rdata", rd, 32'h00001234);
      do_acc(1, 0, 3'b101, 9'h020, 32'h0, wr, wd, dn, er, rd);
      do_acc(1, 1, 3'b000, 9'h101, 32'h000000F7, wr, wd, dn, er, rd);
      chk("sb_lane1_wr", 32'(wr), 32'h2);
      chk("sb_lane1_wdata", wd, 32'hF7F7F7F7);
      do_acc(0, 0, 3'b000, 9'h101, 32'h0, wr, wd, dn, er, rd);
      chk("lb_lane1_rdata", rd, 32'hFFFFFFF7);

      do_acc(0, 0, 3'b010, 9'h005, 32'h0, wr, wd, dn, er, rd);
      chk("lw_mis_err", 32'(er), 32'h1);
      chk("lw_mis_wr", 32'(wr), 32'h0);
      chk("lw_mis_rdata", rd, 32'h0);
      do_acc(1, 1, 3'b001, 9'h003, 32'h11112222, wr, wd, dn, er, rd);
      chk("sh_mis_err", 32'(er), 32'h1);
      chk("sh_mis_done", 32'(dn), 32'h1);
      chk("sh_mis_wr", 32'(wr), 32'h0);
      do_acc(0, 0, 3'b011, 9'h008, 32'h0, wr, wd, dn, er, rd);
      chk("f3_011_err", 32'(er), 32'h1);
      chk("f3_011_rdata", rd, 32'h0);
      do_acc(1, 1, 3'b100, 9'h00C, 32'h33333333, wr, wd, dn, er, rd);
      chk("st_f3_100_err", 32'(er), 32'h1);
      chk("st_f3_100_wr", 32'(wr), 32'h0);
      do_acc(0, 0, 3'b010, 9'h000, 32'h0, wr, wd, dn, er, rd);
      chk("err_untouched_w0", rd, pat(0));

      @(posedge clk); #1;
      bus.req0 = 1; bus.we0 = 1; bus.funct3_0 = 3'b010; bus.addr0 = 9'h040; bus.wdata0 = 32'hFFFFFFFF;
      @(negedge clk);
      chk("abort_gnt", 32'(bus.gnt0), 32'h1);
      @(posedge clk); #1;
      bus.req0 = 0;
      chk("abort_issue_wr", 32'(bus.mem_wr), 32'hF);
      reset = 1;
      #1;
      chk("abort_wr_drop", 32'(bus.mem_wr), 32'h0);
      repeat (2) begin
         @(negedge clk);
         chk("abort_no_done", 32'(bus.done0), 32'h0);
      end
      @(posedge clk); #1 reset = 0;

      @(posedge clk); #1;
      g0 = gnt_log.size();
      bus.req0 = 1; bus.we0 = 0; bus.funct3_0 = 3'b010; bus.addr0 = 9'h010;
      bus.req1 = 1; bus.we1 = 0; bus.funct3_1 = 3'b010; bus.addr1 = 9'h020;
      repeat (12) @(posedge clk);
      #1;
      bus.req0 = 0;
      bus.req1 = 0;
      repeat (2) @(posedge clk);
      chk("alt_count", 32'(gnt_log.size() - g0), 32'd4);
      if (gnt_log.size() - g0 >= 4) begin
         for (int i = 0; i < 4; i++) begin
            chk("alt_port", 32'(gnt_log[g0 + i]), 32'(i % 2));
            if (i > 0) chk("alt_spacing", 32'(gcyc_log[g0 + i] - gcyc_log[g0 + i - 1]), 32'd3);
         end
      end

      do_acc(0, 0, 3'b010, 9'h040, 32'h0, wr, wd, dn, er, rd);
      chk("abort_prior_value", rd, pat(16));
      repeat (2) @(posedge clk);

      for (int i = 0; i < 128; i++) begin
         for (int k = 0; k < 4; k++) w[8*k +: 8] = mb[4*i + k];
         chk("final_mem_word", mem[i], w);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
